pc_step_controller: RTL and testbench
=====================================

Name: pc_step_controller

Overview:
- Upstream sequencing stage for the program counter.
- Turns a raw front-panel step button and run switch into the single-cycle `enable` pulses the PC consumes.
- Detects the HALT opcode on the fetched instruction and drives the PC's `halt` input.
- Provides single-step and free-run (clock-divided) execution, plus a step counter for board display.

Parameters:
- ADDR_W, 5, PC / instruction-address width
- OPCODE_W, 4, width of opcode field compared for halt
- HALT_OPCODE, 4'b1111, opcode that stops execution
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a switch/button level change
- RUN_DIV, 8, cycles between enable pulses in RUN mode (minimum 2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- step_btn  input  1  raw asynchronous step push-button
- run_sw  input  1  raw asynchronous run/step mode switch (1 = run)
- opcode  input  OPCODE_W  opcode field of instruction at current PC
- pc  input  ADDR_W  current instruction address from program counter
- enable  output  1  one-cycle advance pulse to program counter
- halt  output  1  freeze PC; high from halt detection until reset
- state  output  2  FSM state: 0 IDLE, 1 STEP, 2 RUN, 3 HALTED
- step_count  output  8  number of enable pulses issued, saturating

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, enable=0, step_count=0, synchronizers/debounced levels/counters=0. halt is 0 unless opcode==HALT_OPCODE combinationally.
- Input conditioning:
  - step_btn and run_sw each pass through a 2-flop synchronizer.
  - Debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the counter.
  - step request = one-cycle rising edge of debounced step.
- is_halt = (opcode == HALT_OPCODE). halt = (state==HALTED) | is_halt.
- enable is gated: never high while halt is high.
- FSM transitions, priority top-down each cycle:
  - any state, is_halt -> HALTED
  - HALTED: stays until reset; step and run inputs ignored
  - IDLE: debounced run=1 -> RUN; step request -> STEP
  - STEP: enable=1 for exactly this cycle, step_count++, -> IDLE (or RUN if debounced run=1)
  - RUN: rate counter counts 0..RUN_DIV-1 and pulses enable on reaching RUN_DIV-1 (first pulse RUN_DIV cycles after entry); debounced run=0 -> IDLE, counter cleared, no pulse that cycle; step requests ignored
- Latency: raw step rise first sampled at edge k -> enable high in cycle k+DEBOUNCE_CYCLES+3, width 1.
- step_count increments with every enable pulse and saturates at 255; no wrap.
- enable is registered; every output other than halt is driven from flops.
- Reset mid-RUN or mid-debounce discards all pending pulses; no enable in the cycle following reset.

Optional Feature:
- Macro: PC_BREAKPOINT_EN
- With it defined: adds inputs bp_valid (1) and bp_addr (ADDR_W).
  - In RUN, when bp_valid && pc==bp_addr, the FSM goes to IDLE and suppresses that cycle's enable.
  - Run resumes only after debounced run falls and rises again.
  - Single STEP from the breakpoint is allowed and advances past it.
  - Halt keeps priority over breakpoint.
- Without it: no extra ports; RUN continues until run_sw falls or halt.

Test Plan:
- Reset, then step_btn pulsed high for 30 cycles, opcode=0 -> exactly one enable pulse at DEBOUNCE_CYCLES+3=19 cycles after first sample; step_count=1; state returns to IDLE.
- step_btn glitch high 5 cycles (< DEBOUNCE_CYCLES) -> no enable; step_count stays 0.
- run_sw=1 held for 100 cycles after debounce -> enable pulses every 8 cycles, first at 8 cycles after RUN entry; step_count=number of pulses; step_btn presses during RUN produce no extra pulse.
- In RUN, set opcode=4'b1111 -> halt=1 same cycle, enable=0, state=HALTED. Then toggle run_sw/step_btn -> no change. Then reset -> state=IDLE, step_count=0.
- Drive 300 step requests -> step_count saturates at 255.
- (PC_BREAKPOINT_EN) bp_valid=1, bp_addr=5'd6, RUN with pc advancing -> when pc==6, enable suppressed and state=IDLE. One step press -> single enable. run_sw cycled 0->1 -> RUN resumes.

Source files
------------

// File: rtl/pc_step_controller_if.sv
// pc_step_controller_if
//   Bundles the front-panel inputs, the PC-side signals and the controller
//   outputs of pc_step_controller into one interface.
//   Optional feature macro: PC_BREAKPOINT_EN (adds bp_valid / bp_addr).
//
//   Signals
//     step_btn   raw step push-button             (master -> slave)
//     run_sw     raw run/step switch, 1 = run     (master -> slave)
//     opcode     opcode field at current PC       (master -> slave)
//     pc         current instruction address      (master -> slave)
//     bp_valid   breakpoint armed (macro only)    (master -> slave)
//     bp_addr    breakpoint address (macro only)  (master -> slave)
//     enable     one-cycle PC advance pulse       (slave -> master)
//     halt       PC freeze                        (slave -> master)
//     state      0 IDLE, 1 STEP, 2 RUN, 3 HALTED  (slave -> master)
//     step_count saturating count of enables      (slave -> master)
interface pc_step_controller_if #(
  parameter int ADDR_W   = 5,
  parameter int OPCODE_W = 4
);
  logic                step_btn;
  logic                run_sw;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   pc;
`ifdef PC_BREAKPOINT_EN
  logic                bp_valid;
  logic [ADDR_W-1:0]   bp_addr;
`endif
  logic                enable;
  logic                halt;
  logic [1:0]          state;
  logic [7:0]          step_count;

  modport master (
`ifdef PC_BREAKPOINT_EN
    output bp_valid, bp_addr,
`endif
    output step_btn, run_sw, opcode, pc,
    input  enable, halt, state, step_count
  );

  modport slave (
`ifdef PC_BREAKPOINT_EN
    input  bp_valid, bp_addr,
`endif
    input  step_btn, run_sw, opcode, pc,
    output enable, halt, state, step_count
  );
endinterface

// File: rtl/pc_step_controller.sv
// pc_step_controller
//   Sequencing stage in front of the program counter. Conditions the raw
//   step button and run switch (2-flop synchronizer + debounce), issues
//   single-cycle enable pulses in STEP or clock-divided RUN mode, detects
//   the HALT opcode and counts issued pulses (saturating at 255).
//   Optional feature macro: PC_BREAKPOINT_EN (RUN stops at bp_addr).
//
//   Ports
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    pc_step_controller_if.slave (step_btn, run_sw, opcode, pc,
//            [bp_valid, bp_addr], enable, halt, state, step_count)
module pc_step_controller #(
  parameter int                   ADDR_W          = 5,
  parameter int                   OPCODE_W        = 4,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE     = OPCODE_W'(4'b1111),
  parameter int                   DEBOUNCE_CYCLES = 16,
  parameter int                   RUN_DIV         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_step_controller_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RATE_W = $clog2(RUN_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Input conditioning: channel 0 = step button, channel 1 = run switch.
  logic [1:0] raw_in;
  logic [1:0] deb_lvl;
  assign raw_in = {bus.run_sw, bus.step_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    logic            sync1_q;
    logic            sync2_q;
    logic            deb_q;
    logic [DB_W-1:0] db_cnt_q;

    // The debounced level only moves after the synchronized level has
    // disagreed with it for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        deb_q    <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        sync1_q <= raw_in[gi];
        sync2_q <= sync1_q;
        if (sync2_q == deb_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q    <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

    assign deb_lvl[gi] = deb_q;
  end

  logic run_lvl;
  logic step_prev_q;
  logic step_req;
  assign run_lvl  = deb_lvl[1];
  assign step_req = deb_lvl[0] & ~step_prev_q;

  logic is_halt;
  assign is_halt = (bus.opcode == HALT_OPCODE);

  state_e              state_q, state_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                enable_q, enable_d;
  logic [7:0]          count_q, count_d;
  logic                bp_block_q, bp_block_d;
  logic                run_ok;
  logic                bp_hit;

`ifdef PC_BREAKPOINT_EN
  assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr);
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
  assign bp_hit    = 1'b0;
`endif

  // After a breakpoint, RUN may only be re-entered once the debounced run
  // level has gone low and come back up.
  assign run_ok = run_lvl & ~bp_block_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rate_q      <= '0;
      enable_q    <= 1'b0;
      count_q     <= '0;
      bp_block_q  <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      enable_q    <= enable_d;
      count_q     <= count_d;
      bp_block_q  <= bp_block_d;
      step_prev_q <= deb_lvl[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    rate_d     = '0;
    enable_d   = 1'b0;
    bp_block_d = bp_block_q & run_lvl;
    if (is_halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_ok)        state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
        ST_STEP: begin
          enable_d = 1'b1;
          state_d  = run_ok ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!run_lvl) begin
            state_d = ST_IDLE;
          end else if (bp_hit) begin
            state_d    = ST_IDLE;
            bp_block_d = 1'b1;
          end else if (rate_q == RATE_W'(RUN_DIV - 1)) begin
            enable_d = 1'b1;
          end else begin
            rate_d = rate_q + 1'b1;
          end
        end
        default: state_d = ST_HALTED;
      endcase
    end
    count_d = count_q;
    if (enable_d && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  // enable is a flop; the halt gate keeps it low whenever a halt opcode
  // appears in the same cycle as a pending pulse.
  assign bus.halt       = (state_q == ST_HALTED) | is_halt;
  assign bus.enable     = enable_q & ~bus.halt;
  assign bus.state      = state_q;
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_pc_step_controller.sv
module tb_pc_step_controller;
  localparam int D   = 16;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   en_q[$];
  logic [4:0] pc_v = '0;

  pc_step_controller_if #(.ADDR_W(5), .OPCODE_W(4)) intf();
  pc_step_controller dut (.clk(clk), .reset(reset), .bus(intf));

  assign intf.pc = pc_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records the cycle of every enable pulse and plays the role of
  // the program counter (advances on enable).
  always @(negedge clk) begin
    if (reset) pc_v = '0;
    else if (intf.enable === 1'b1) begin
      en_q.push_back(cyc);
      pc_v = pc_v + 5'd1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    intf.step_btn = 1'b0;
    intf.run_sw   = 1'b0;
    intf.opcode   = 4'd0;
`ifdef PC_BREAKPOINT_EN
    intf.bp_valid = 1'b0;
    intf.bp_addr  = 5'd0;
`endif
    tick(3);
    reset = 1'b0;
    en_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    intf.opcode = 4'hF;
    #1;
    chk_cnt++; if (intf.halt !== 1'b1) $display("FAIL reset_halt_comb: got %0b expected 1", intf.halt); else pass_cnt++;
    intf.opcode = 4'h0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", intf.state); else pass_cnt++;
    chk_cnt++; if (intf.enable !== 1'b0) $display("FAIL reset_enable: got %0b expected 0", intf.enable); else pass_cnt++;
    chk_cnt++; if (intf.step_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", intf.step_count); else pass_cnt++;
    chk_cnt++; if (intf.halt !== 1'b0) $display("FAIL reset_halt: got %0b expected 0", intf.halt); else pass_cnt++;
  endtask

  task automatic test_single_step();
    int c;
    en_q.delete();
    c = cyc;
    intf.step_btn = 1'b1;
    tick(30);
    intf.step_btn = 1'b0;
    tick(40);
    chk_cnt++; if (en_q.size() !== 1) $display("FAIL step_pulses: got %0d expected 1", en_q.size()); else pass_cnt++;
    if (en_q.size() > 0) begin
      chk_cnt++; if (en_q[0] !== c + D + 4) $display("FAIL step_latency: got cycle %0d expected %0d", en_q[0], c + D + 4); else pass_cnt++;
    end
    chk_cnt++; if (intf.step_count !== 8'd1) $display("FAIL step_count: got %0d expected 1", intf.step_count); else pass_cnt++;
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL step_state: got %0d expected 0", intf.state); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [7:0] cnt0;
    en_q.delete();
    cnt0 = intf.step_count;
    intf.step_btn = 1'b1;
    tick(5);
    intf.step_btn = 1'b0;
    tick(40);
    chk_cnt++; if (en_q.size() !== 0) $display("FAIL glitch_pulses: got %0d expected 0", en_q.size()); else pass_cnt++;
    chk_cnt++; if (intf.step_count !== cnt0) $display("FAIL glitch_count: got %0d expected %0d", intf.step_count, cnt0); else pass_cnt++;
  endtask

  // Random press lengths: a press is accepted iff it lasts >= D cycles.
  task automatic test_random_steps();
    int exp_q[$];
    int exp_cnt;
    int c, len;
    en_q.delete();
    exp_cnt = int'(intf.step_count);
    for (int i = 0; i < 12; i++) begin
      len = $urandom_range(4, 30);
      c = cyc;
      intf.step_btn = 1'b1;
      tick(len);
      intf.step_btn = 1'b0;
      tick(D + 10);
      if (len >= D) begin
        exp_q.push_back(c + D + 4);
        exp_cnt++;
      end
    end
    chk_cnt++; if (en_q.size() !== exp_q.size()) $display("FAIL rand_pulses: got %0d expected %0d", en_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < en_q.size(); i++) begin
      chk_cnt++; if (en_q[i] !== exp_q[i]) $display("FAIL rand_time[%0d]: got %0d expected %0d", i, en_q[i], exp_q[i]); else pass_cnt++;
    end
    chk_cnt++; if (int'(intf.step_count) !== exp_cnt) $display("FAIL rand_count: got %0d expected %0d", intf.step_count, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_run();
    int exp_q[$];
    int c, e, f, hold, cnt0;
    en_q.delete();
    cnt0 = int'(intf.step_count);
    hold = $urandom_range(100, 130);
    c = cyc;
    intf.run_sw = 1'b1;
    e = c + D + 3;
    tick(D + 2);
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL run_pre_entry: got %0d expected 0", intf.state); else pass_cnt++;
    tick(1);
    chk_cnt++; if (intf.state !== 2'd2) $display("FAIL run_entry: got %0d expected 2", intf.state); else pass_cnt++;
    tick(20);
    intf.step_btn = 1'b1;
    tick(20);
    intf.step_btn = 1'b0;
    tick(e + hold - cyc);
    chk_cnt++; if (intf.state !== 2'd2) $display("FAIL run_hold_state: got %0d expected 2", intf.state); else pass_cnt++;
    intf.run_sw = 1'b0;
    f = cyc + 1;
    tick(D + 10);
    for (int t = e + DIV; t <= f + D + 1; t += DIV) exp_q.push_back(t);
    chk_cnt++; if (en_q.size() !== exp_q.size()) $display("FAIL run_pulses: got %0d expected %0d", en_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < en_q.size(); i++) begin
      chk_cnt++; if (en_q[i] !== exp_q[i]) $display("FAIL run_time[%0d]: got %0d expected %0d", i, en_q[i], exp_q[i]); else pass_cnt++;
    end
    chk_cnt++; if (int'(intf.step_count) !== cnt0 + exp_q.size()) $display("FAIL run_count: got %0d expected %0d", intf.step_count, cnt0 + exp_q.size()); else pass_cnt++;
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL run_exit_state: got %0d expected 0", intf.state); else pass_cnt++;
  endtask

  task automatic test_halt();
    int sz_h;
    logic [7:0] cnt_h;
    intf.run_sw = 1'b1;
    tick(D + 3 + $urandom_range(10, 30));
    intf.opcode = 4'hF;
    #1;
    chk_cnt++; if (intf.halt !== 1'b1) $display("FAIL halt_same_cycle: got %0b expected 1", intf.halt); else pass_cnt++;
    chk_cnt++; if (intf.enable !== 1'b0) $display("FAIL halt_enable: got %0b expected 0", intf.enable); else pass_cnt++;
    sz_h  = en_q.size();
    cnt_h = intf.step_count;
    tick(1);
    chk_cnt++; if (intf.state !== 2'd3) $display("FAIL halt_state: got %0d expected 3", intf.state); else pass_cnt++;
    intf.opcode = 4'h0;
    for (int i = 0; i < 3; i++) begin
      intf.run_sw = ~intf.run_sw;
      intf.step_btn = 1'b1;
      tick(25);
      intf.step_btn = 1'b0;
      tick(25);
    end
    chk_cnt++; if (intf.state !== 2'd3) $display("FAIL halt_sticky_state: got %0d expected 3", intf.state); else pass_cnt++;
    chk_cnt++; if (intf.halt !== 1'b1) $display("FAIL halt_sticky: got %0b expected 1", intf.halt); else pass_cnt++;
    chk_cnt++; if (en_q.size() !== sz_h) $display("FAIL halt_pulses: got %0d expected %0d", en_q.size(), sz_h); else pass_cnt++;
    chk_cnt++; if (intf.step_count !== cnt_h) $display("FAIL halt_count: got %0d expected %0d", intf.step_count, cnt_h); else pass_cnt++;
    do_reset();
    tick(1);
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL halt_reset_state: got %0d expected 0", intf.state); else pass_cnt++;
    chk_cnt++; if (intf.step_count !== 8'd0) $display("FAIL halt_reset_count: got %0d expected 0", intf.step_count); else pass_cnt++;
    chk_cnt++; if (intf.halt !== 1'b0) $display("FAIL halt_reset_halt: got %0b expected 0", intf.halt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_activity();
    intf.run_sw = 1'b1;
    tick(D + 3 + 6);
    intf.step_btn = 1'b1;
    tick(10);
    do_reset();
    tick(40);
    chk_cnt++; if (en_q.size() !== 0) $display("FAIL midreset_pulses: got %0d expected 0", en_q.size()); else pass_cnt++;
    chk_cnt++; if (intf.step_count !== 8'd0) $display("FAIL midreset_count: got %0d expected 0", intf.step_count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int len;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      len = $urandom_range(D + 1, D + 6);
      intf.step_btn = 1'b1;
      tick(len);
      intf.step_btn = 1'b0;
      tick(D + 6);
      if (n == 254 || n == 255 || n == 256 || n == 300) begin
        chk_cnt++; if (int'(intf.step_count) !== ((n < 255) ? n : 255)) $display("FAIL sat_count_%0d: got %0d expected %0d", n, intf.step_count, (n < 255) ? n : 255); else pass_cnt++;
      end
    end
    chk_cnt++; if (en_q.size() !== 300) $display("FAIL sat_pulses: got %0d expected 300", en_q.size()); else pass_cnt++;
  endtask

`ifdef PC_BREAKPOINT_EN
  task automatic test_breakpoint();
    int c, e;
    do_reset();
    intf.bp_valid = 1'b1;
    intf.bp_addr  = 5'd6;
    c = cyc;
    intf.run_sw = 1'b1;
    e = c + D + 3;
    tick(D + 3 + 70);
    chk_cnt++; if (en_q.size() !== 6) $display("FAIL bp_pulses: got %0d expected 6", en_q.size()); else pass_cnt++;
    if (en_q.size() == 6) begin
      chk_cnt++; if (en_q[5] !== e + 6 * DIV) $display("FAIL bp_last_time: got %0d expected %0d", en_q[5], e + 6 * DIV); else pass_cnt++;
    end
    chk_cnt++; if (pc_v !== 5'd6) $display("FAIL bp_pc: got %0d expected 6", pc_v); else pass_cnt++;
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL bp_state: got %0d expected 0", intf.state); else pass_cnt++;
    intf.step_btn = 1'b1;
    tick(25);
    intf.step_btn = 1'b0;
    tick(30);
    chk_cnt++; if (en_q.size() !== 7) $display("FAIL bp_step_pulses: got %0d expected 7", en_q.size()); else pass_cnt++;
    chk_cnt++; if (pc_v !== 5'd7) $display("FAIL bp_step_pc: got %0d expected 7", pc_v); else pass_cnt++;
    chk_cnt++; if (intf.state !== 2'd0) $display("FAIL bp_blocked_state: got %0d expected 0", intf.state); else pass_cnt++;
    intf.run_sw = 1'b0;
    tick(30);
    intf.run_sw = 1'b1;
    tick(D + 4);
    chk_cnt++; if (intf.state !== 2'd2) $display("FAIL bp_resume_state: got %0d expected 2", intf.state); else pass_cnt++;
    intf.run_sw   = 1'b0;
    intf.bp_valid = 1'b0;
    tick(30);
  endtask
`endif

  initial begin
    intf.step_btn = 1'b0;
    intf.run_sw   = 1'b0;
    intf.opcode   = 4'd0;
`ifdef PC_BREAKPOINT_EN
    intf.bp_valid = 1'b0;
    intf.bp_addr  = 5'd0;
`endif
    tick(1);
    test_reset();
    test_single_step();
    test_glitch();
    test_random_steps();
    test_run();
    test_halt();
    test_reset_mid_activity();
    test_saturation();
`ifdef PC_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
